// File: rtl/rx_align_ctrl_pkg.sv
// rx_align_ctrl_pkg: phy_rx lane state encodings, comma character and default link constants
package rx_align_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_ALIGN  = 2'd2,
    ST_ACTIVE = 2'd3
  } link_state_e;
  localparam logic [7:0] COMMA_CHAR = 8'hBC;
  localparam int unsigned SYNC_COUNT_DEF  = 4;
  localparam int unsigned SLIP_WAIT_DEF   = 2;
  localparam int unsigned GAP_TIMEOUT_DEF = 64;
endpackage

// File: rtl/rx_align_ctrl_gap_timer.sv
// rx_align_ctrl_gap_timer: saturating run counter that flags the LIMIT-th consecutive increment
module rx_align_ctrl_gap_timer
  import rx_align_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = GAP_TIMEOUT_DEF
) (
  input  logic clk_f,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic timeout
);
  localparam int unsigned W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    timeout = inc && !clr && cnt_q == W'(LIMIT - 1);
    cnt_d   = (clr || timeout) ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_f or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/rx_align_ctrl.sv
// rx_align_ctrl: bitslip-driven comma alignment and link-state FSM for the phy_rx lane
module rx_align_ctrl
  import rx_align_ctrl_pkg::*;
#(
  parameter logic [7:0]  COMMA       = COMMA_CHAR,
  parameter int unsigned SYNC_COUNT  = SYNC_COUNT_DEF,
  parameter int unsigned SLIP_WAIT   = SLIP_WAIT_DEF,
  parameter int unsigned GAP_TIMEOUT = GAP_TIMEOUT_DEF
) (
  input  logic       clk_f,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_in,
  output logic       bitslip,
  output logic       active,
  output logic       valid_out,
  output logic [7:0] data_out,
  output logic       sync_lost,
  output logic [1:0] state_out
);
  localparam int unsigned CW = $clog2(SYNC_COUNT + 1);
  localparam int unsigned BW = $clog2(SLIP_WAIT + 1);
  link_state_e state_q, state_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d;
  logic [BW-1:0] blank_q, blank_d;
  logic bitslip_q, bitslip_d, active_q, active_d, valid_q, valid_d, sync_lost_q, sync_lost_d;
  logic [7:0] data_q, data_d;
  logic is_comma, gap_clr, gap_timeout;
  assign is_comma = data_in == COMMA;
  assign gap_clr  = !enable || state_q != ST_ACTIVE || is_comma;
  rx_align_ctrl_gap_timer #(.LIMIT(GAP_TIMEOUT)) u_gap (
    .clk_f   (clk_f),
    .reset   (reset),
    .clr     (gap_clr),
    .inc     (!is_comma),
    .timeout (gap_timeout)
  );
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    blank_d     = blank_q;
    bitslip_d   = 1'b0;
    active_d    = 1'b0;
    valid_d     = 1'b0;
    data_d      = '0;
    sync_lost_d = 1'b0;
    if (!enable) begin
      state_d     = ST_IDLE;
      comma_cnt_d = '0;
      blank_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_HUNT;
        ST_HUNT:
          if (|blank_q) blank_d = blank_q - 1'b1;
          else if (is_comma) begin
            state_d     = ST_ALIGN;
            comma_cnt_d = CW'(1);
          end else begin
            bitslip_d = 1'b1;
            blank_d   = BW'(SLIP_WAIT);
          end
        ST_ALIGN:
          // A broken comma run re-hunts without slipping; the slip rule resumes next cycle
          if (!is_comma) begin
            state_d     = ST_HUNT;
            comma_cnt_d = '0;
            blank_d     = '0;
          end else if (comma_cnt_q == CW'(SYNC_COUNT - 1)) begin
            state_d     = ST_ACTIVE;
            comma_cnt_d = '0;
            active_d    = 1'b1;
          end else comma_cnt_d = comma_cnt_q + 1'b1;
        default:
          if (gap_timeout) begin
            state_d     = ST_HUNT;
            sync_lost_d = 1'b1;
          end else begin
            active_d = 1'b1;
            valid_d  = !is_comma;
            data_d   = is_comma ? '0 : data_in;
          end
      endcase
    end
  end
  always_ff @(posedge clk_f or negedge reset)
    if (!reset) begin
      state_q     <= ST_IDLE;
      comma_cnt_q <= '0;
      blank_q     <= '0;
      bitslip_q   <= 1'b0;
      active_q    <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      sync_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      blank_q     <= blank_d;
      bitslip_q   <= bitslip_d;
      active_q    <= active_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      sync_lost_q <= sync_lost_d;
    end
  assign bitslip   = bitslip_q;
  assign active    = active_q;
  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign sync_lost = sync_lost_q;
  assign state_out = state_q;
endmodule
